// File: rtl/system_ram_dp.sv
// system_ram_dp: dual-port byte-writable system RAM.
//   Port A: read/write (read-first), byte write mask, request/valid handshake.
//   Port B: read-only, request/valid handshake.
//   READ_LATENCY of 1 or 2 cycles from accepted request to valid data.
//
// Ports:
//   clk_i            system clock, rising edge
//   reset_i          synchronous active-high reset (flushes pipelines, zeroes outputs)
//   a_req_i          port A request
//   a_addr_i         port A byte address
//   a_write_data_i   port A write data
//   a_write_mask_i   port A byte write enables (all zero = pure read)
//   a_read_data_o    port A read data, held between valid pulses
//   a_read_valid_o   port A read data valid
//   b_req_i          port B read request
//   b_addr_i         port B byte address
//   b_read_data_o    port B read data, held between valid pulses
//   b_read_valid_o   port B read data valid
//
// Build options:
//   SYSTEM_RAM_WRITE_FORWARD_EN  port B sees port A's same-cycle write (merged bytes)
//   ENABLE_XILINX_PRIMITIVES     use an XPM true-dual-port RAM instead of the array

module system_ram_dp #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    a_req_i,
    input  logic [31:0]             a_addr_i,
    input  logic [DATA_WIDTH-1:0]   a_write_data_i,
    input  logic [DATA_WIDTH/8-1:0] a_write_mask_i,
    output logic [DATA_WIDTH-1:0]   a_read_data_o,
    output logic                    a_read_valid_o,
    input  logic                    b_req_i,
    input  logic [31:0]             b_addr_i,
    output logic [DATA_WIDTH-1:0]   b_read_data_o,
    output logic                    b_read_valid_o
);

    localparam int unsigned NUM_BYTES  = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(NUM_BYTES);
    localparam int unsigned INDEX_BITS = $clog2(DEPTH);

    logic [INDEX_BITS-1:0] a_idx;
    logic [INDEX_BITS-1:0] b_idx;
    logic                  a_en;
    logic                  b_en;
    logic [DATA_WIDTH-1:0] a_raw;
    logic [DATA_WIDTH-1:0] b_raw;
    logic [DATA_WIDTH-1:0] b_stage1;
    logic                  a_vld1_q;
    logic                  b_vld1_q;
    logic                  unused_addr_bits;

    // Offset bits and bits above the index are dropped; addresses wrap modulo DEPTH.
    assign a_idx = a_addr_i[ADDR_LSB +: INDEX_BITS];
    assign b_idx = b_addr_i[ADDR_LSB +: INDEX_BITS];
    assign unused_addr_bits = ^{a_addr_i, b_addr_i};

    assign a_en = a_req_i & ~reset_i;
    assign b_en = b_req_i & ~reset_i;

`ifdef ENABLE_XILINX_PRIMITIVES
    // Stage-1 read registers live inside the primitive; rst zeroes them like the array model.
    xpm_memory_tdpram #(
        .MEMORY_SIZE        (DEPTH * DATA_WIDTH),
        .MEMORY_PRIMITIVE   ("block"),
        .CLOCKING_MODE      ("common_clock"),
        .WRITE_DATA_WIDTH_A (DATA_WIDTH),
        .READ_DATA_WIDTH_A  (DATA_WIDTH),
        .BYTE_WRITE_WIDTH_A (8),
        .ADDR_WIDTH_A       (INDEX_BITS),
        .READ_LATENCY_A     (1),
        .READ_RESET_VALUE_A ("0"),
        .WRITE_MODE_A       ("read_first"),
        .WRITE_DATA_WIDTH_B (DATA_WIDTH),
        .READ_DATA_WIDTH_B  (DATA_WIDTH),
        .BYTE_WRITE_WIDTH_B (8),
        .ADDR_WIDTH_B       (INDEX_BITS),
        .READ_LATENCY_B     (1),
        .READ_RESET_VALUE_B ("0"),
        .WRITE_MODE_B       ("read_first")
    ) u_xpm_ram (
        .clka           (clk_i),
        .clkb           (clk_i),
        .rsta           (reset_i),
        .rstb           (reset_i),
        .ena            (a_en),
        .enb            (b_en),
        .regcea         (1'b1),
        .regceb         (1'b1),
        .wea            (a_write_mask_i),
        .web            ({NUM_BYTES{1'b0}}),
        .addra          (a_idx),
        .addrb          (b_idx),
        .dina           (a_write_data_i),
        .dinb           ({DATA_WIDTH{1'b0}}),
        .injectsbiterra (1'b0),
        .injectdbiterra (1'b0),
        .injectsbiterrb (1'b0),
        .injectdbiterrb (1'b0),
        .sleep          (1'b0),
        .douta          (a_raw),
        .doutb          (b_raw),
        .sbiterra       (),
        .dbiterra       (),
        .sbiterrb       (),
        .dbiterrb       ()
    );
`else
    // Contents start at zero and survive reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Byte-masked write from port A.
    always_ff @(posedge clk_i) begin
        if (a_en) begin
            for (int k = 0; k < int'(NUM_BYTES); k++) begin
                if (a_write_mask_i[k]) begin
                    mem[a_idx][k*8 +: 8] <= a_write_data_i[k*8 +: 8];
                end
            end
        end
    end

    // Stage-1 read registers; non-blocking reads give read-first on both ports.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_raw <= '0;
            b_raw <= '0;
        end else begin
            if (a_req_i) a_raw <= mem[a_idx];
            if (b_req_i) b_raw <= mem[b_idx];
        end
    end
`endif

    // Stage-1 valid flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_vld1_q <= 1'b0;
            b_vld1_q <= 1'b0;
        end else begin
            a_vld1_q <= a_req_i;
            b_vld1_q <= b_req_i;
        end
    end

`ifdef SYSTEM_RAM_WRITE_FORWARD_EN
    logic [NUM_BYTES-1:0]  b_fwd_mask_q;
    logic [DATA_WIDTH-1:0] b_fwd_data_q;

    // Capture A's write bytes when B reads the same word in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            b_fwd_mask_q <= '0;
            b_fwd_data_q <= '0;
        end else if (b_req_i) begin
            b_fwd_mask_q <= (a_req_i && (a_idx == b_idx)) ? a_write_mask_i : '0;
            b_fwd_data_q <= a_write_data_i;
        end
    end

    // Merge forwarded bytes over the stored word.
    always_comb begin
        b_stage1 = b_raw;
        for (int k = 0; k < int'(NUM_BYTES); k++) begin
            if (b_fwd_mask_q[k]) begin
                b_stage1[k*8 +: 8] = b_fwd_data_q[k*8 +: 8];
            end
        end
    end
`else
    assign b_stage1 = b_raw;
`endif

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign a_read_data_o  = a_raw;
            assign a_read_valid_o = a_vld1_q;
            assign b_read_data_o  = b_stage1;
            assign b_read_valid_o = b_vld1_q;
        end else begin : g_lat2
            logic [DATA_WIDTH-1:0] a_out_q;
            logic [DATA_WIDTH-1:0] b_out_q;
            logic                  a_vld2_q;
            logic                  b_vld2_q;

            // Output stage loads only on a valid beat, so data holds in between.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    a_out_q  <= '0;
                    b_out_q  <= '0;
                    a_vld2_q <= 1'b0;
                    b_vld2_q <= 1'b0;
                end else begin
                    a_vld2_q <= a_vld1_q;
                    b_vld2_q <= b_vld1_q;
                    if (a_vld1_q) a_out_q <= a_raw;
                    if (b_vld1_q) b_out_q <= b_stage1;
                end
            end

            assign a_read_data_o  = a_out_q;
            assign a_read_valid_o = a_vld2_q;
            assign b_read_data_o  = b_out_q;
            assign b_read_valid_o = b_vld2_q;
        end
    endgenerate

endmodule

// File: tb/tb_system_ram_dp.sv
module tb_system_ram_dp;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        a_req_i;
    logic [31:0] a_addr_i;
    logic [31:0] a_write_data_i;
    logic [3:0]  a_write_mask_i;
    logic        b_req_i;
    logic [31:0] b_addr_i;

    logic [31:0] a_rd1, b_rd1, a_rd2, b_rd2;
    logic        a_v1, b_v1, a_v2, b_v2;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SYSTEM_RAM_WRITE_FORWARD_EN
    localparam logic [31:0] COLL_EXP = 32'h0000_FFFF;
`else
    localparam logic [31:0] COLL_EXP = 32'h0000_0000;
`endif

    always #5 clk_i = ~clk_i;

    system_ram_dp #(.DEPTH(1024), .DATA_WIDTH(32), .READ_LATENCY(1)) u_rl1 (
        .clk_i(clk_i), .reset_i(reset_i),
        .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_write_data_i(a_write_data_i),
        .a_write_mask_i(a_write_mask_i), .a_read_data_o(a_rd1), .a_read_valid_o(a_v1),
        .b_req_i(b_req_i), .b_addr_i(b_addr_i), .b_read_data_o(b_rd1), .b_read_valid_o(b_v1)
    );

    system_ram_dp #(.DEPTH(1024), .DATA_WIDTH(32), .READ_LATENCY(2)) u_rl2 (
        .clk_i(clk_i), .reset_i(reset_i),
        .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_write_data_i(a_write_data_i),
        .a_write_mask_i(a_write_mask_i), .a_read_data_o(a_rd2), .a_read_valid_o(a_v2),
        .b_req_i(b_req_i), .b_addr_i(b_addr_i), .b_read_data_o(b_rd2), .b_read_valid_o(b_v2)
    );

    // One cycle of stimulus plus the latency-1 outputs expected after its edge.
    typedef struct {
        logic        a_req;
        logic [31:0] a_addr;
        logic [31:0] a_wd;
        logic [3:0]  a_mask;
        logic        b_req;
        logic [31:0] b_addr;
        logic        e_av;
        logic [31:0] e_ad;
        logic        e_bv;
        logic [31:0] e_bd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ar, input logic [31:0] aa, input logic [31:0] wd,
                       input logic [3:0] m, input logic br, input logic [31:0] ba,
                       input logic eav, input logic [31:0] ead,
                       input logic ebv, input logic [31:0] ebd);
        vec_t v;
        v.a_req = ar; v.a_addr = aa; v.a_wd = wd; v.a_mask = m;
        v.b_req = br; v.b_addr = ba;
        v.e_av = eav; v.e_ad = ead; v.e_bv = ebv; v.e_bd = ebd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name,
                         input logic av, input logic [31:0] ad,
                         input logic bv, input logic [31:0] bd,
                         input logic eav, input logic [31:0] ead,
                         input logic ebv, input logic [31:0] ebd);
        n_tests++;
        if ({av, ad, bv, bd} !== {eav, ead, ebv, ebd}) begin
            n_fail++;
            $display("FAIL %s: got a_v=%0b a_d=%08h b_v=%0b b_d=%08h, expected a_v=%0b a_d=%08h b_v=%0b b_d=%08h",
                     name, av, ad, bv, bd, eav, ead, ebv, ebd);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        a_req_i = 1'b0; a_addr_i = '0; a_write_data_i = '0; a_write_mask_i = '0;
        b_req_i = 1'b0; b_addr_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t prev;
        int   waited;

        //   a_req a_addr     wdata         mask   b_req b_addr      e_av e_ad          e_bv e_bd
        add(1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0,    1, 32'h0,        0, 32'h0);
        add(1, 32'h10,   32'h0,        4'h0, 0, 32'h0,    1, 32'hDEADBEEF, 0, 32'h0);
        add(1, 32'h20,   32'h11223344, 4'hF, 0, 32'h0,    1, 32'h0,        0, 32'h0);
        add(1, 32'h20,   32'hAABBCCDD, 4'h5, 0, 32'h0,    1, 32'h11223344, 0, 32'h0);
        add(0, 32'h0,    32'h0,        4'h0, 1, 32'h20,   0, 32'h11223344, 1, 32'h11BB33DD);
        add(1, 32'h0,    32'h1,        4'hF, 0, 32'h0,    1, 32'h0,        0, 32'h11BB33DD);
        add(1, 32'h4,    32'h2,        4'hF, 0, 32'h0,    1, 32'h0,        0, 32'h11BB33DD);
        add(1, 32'h8,    32'h3,        4'hF, 0, 32'h0,    1, 32'h0,        0, 32'h11BB33DD);
        add(1, 32'hC,    32'h4,        4'hF, 0, 32'h0,    1, 32'h0,        0, 32'h11BB33DD);
        add(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,    0, 32'h0,        1, 32'h1);
        add(0, 32'h0,    32'h0,        4'h0, 1, 32'h4,    0, 32'h0,        1, 32'h2);
        add(0, 32'h0,    32'h0,        4'h0, 1, 32'h8,    0, 32'h0,        1, 32'h3);
        add(0, 32'h0,    32'h0,        4'h0, 1, 32'hC,    0, 32'h0,        1, 32'h4);
        add(0, 32'h0,    32'h0,        4'h0, 0, 32'h0,    0, 32'h0,        0, 32'h4);
        add(1, 32'h40,   32'hFFFFFFFF, 4'h3, 1, 32'h40,   1, 32'h0,        1, COLL_EXP);
        add(0, 32'h0,    32'h0,        4'h0, 1, 32'h40,   0, 32'h0,        1, 32'h0000FFFF);
        add(1, 32'h1004, 32'h1234,     4'hF, 0, 32'h0,    1, 32'h2,        0, 32'h0000FFFF);
        add(0, 32'h0,    32'h0,        4'h0, 1, 32'h4,    0, 32'h2,        1, 32'h1234);
        add(0, 32'h0,    32'h0,        4'h0, 1, 32'h6,    0, 32'h2,        1, 32'h1234);
        add(1, 32'h1007, 32'h0,        4'h0, 0, 32'h0,    1, 32'h1234,     0, 32'h1234);
        add(0, 32'h0,    32'h0,        4'h0, 0, 32'h0,    0, 32'h1234,     0, 32'h1234);

        idle_inputs();
        reset_i = 1'b1;
        step();
        step();
        check("reset_rl1", a_v1, a_rd1, b_v1, b_rd1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("reset_rl2", a_v2, a_rd2, b_v2, b_rd2, 1'b0, 32'h0, 1'b0, 32'h0);
        reset_i = 1'b0;

        // Latency-2 outputs trail the latency-1 expectations by exactly one row.
        prev = '{default: '0};
        for (int i = 0; i < vecs.size(); i++) begin
            a_req_i = vecs[i].a_req; a_addr_i = vecs[i].a_addr;
            a_write_data_i = vecs[i].a_wd; a_write_mask_i = vecs[i].a_mask;
            b_req_i = vecs[i].b_req; b_addr_i = vecs[i].b_addr;
            step();
            check($sformatf("vec%0d_rl1", i), a_v1, a_rd1, b_v1, b_rd1,
                  vecs[i].e_av, vecs[i].e_ad, vecs[i].e_bv, vecs[i].e_bd);
            check($sformatf("vec%0d_rl2", i), a_v2, a_rd2, b_v2, b_rd2,
                  prev.e_av, prev.e_ad, prev.e_bv, prev.e_bd);
            prev = vecs[i];
        end

        // Reset mid-operation: B read in flight, reset with an A write pending.
        idle_inputs();
        b_req_i = 1'b1; b_addr_i = 32'h0;
        step();
        check("rst_pre_rl1", a_v1, a_rd1, b_v1, b_rd1, 1'b0, 32'h1234, 1'b1, 32'h1);
        idle_inputs();
        reset_i = 1'b1;
        a_req_i = 1'b1; a_addr_i = 32'h0; a_write_data_i = 32'h5555_5555; a_write_mask_i = 4'hF;
        step();
        check("rst_e1_rl1", a_v1, a_rd1, b_v1, b_rd1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rst_e1_rl2", a_v2, a_rd2, b_v2, b_rd2, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        check("rst_e2_rl2", a_v2, a_rd2, b_v2, b_rd2, 1'b0, 32'h0, 1'b0, 32'h0);
        idle_inputs();
        reset_i = 1'b0;
        step();
        check("post_rst_e3_rl1", a_v1, a_rd1, b_v1, b_rd1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("post_rst_e3_rl2", a_v2, a_rd2, b_v2, b_rd2, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        check("post_rst_e4_rl2", a_v2, a_rd2, b_v2, b_rd2, 1'b0, 32'h0, 1'b0, 32'h0);

        // The write presented during reset must not have landed.
        b_req_i = 1'b1; b_addr_i = 32'h0;
        step();
        check("post_rst_read_rl1", a_v1, a_rd1, b_v1, b_rd1, 1'b0, 32'h0, 1'b1, 32'h1);
        idle_inputs();
        waited = 0;
        while (!b_v2 && waited < 4) begin
            step();
            waited++;
        end
        check("post_rst_read_rl2", a_v2, a_rd2, b_v2, b_rd2, 1'b0, 32'h0, 1'b1, 32'h1);
        n_tests++;
        if (waited != 1) begin
            n_fail++;
            $display("FAIL post_rst_latency_rl2: got %0d extra cycles, expected 1", waited);
        end
        step();
        check("post_rst_hold_rl2", a_v2, a_rd2, b_v2, b_rd2, 1'b0, 32'h0, 1'b0, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
